// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall/flush scheduler for the in-order pipeline.
// It resolves three hazard sources: load-use, mul/div occupancy and
// control-flow redirect. The redirect case also kills stale fetches.
// Outputs are combinational from the current state and the inputs.
// Reset forces every output to 0.
// Optional feature macro: PIPE_CTRL_PERF_EN adds the stall and flush
// event counters.
module pipe_ctrl #(
    parameter int REG_ADDR_W  = 5,
    parameter int MDU_LAT     = 32,
    parameter int KILL_CYCLES = 1,
    parameter int CNT_W       = 6
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_rs1_used,
    input  logic                  id_rs2_used,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_mem_read,
    input  logic                  ex_mdu_start,
    input  logic                  ex_redirect,
    output logic                  pc_hold,
    output logic                  if_id_stall,
    output logic                  if_id_flush,
    output logic                  id_ex_stall,
    output logic                  id_ex_flush,
    output logic                  ex_stall,
    output logic                  mdu_done
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0]           perf_stall_cnt,
    output logic [31:0]           perf_flush_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MDU_WAIT = 2'd1,
        ST_KILL     = 2'd2
    } state_e;

    // Counter reload values. The start cycle counts as one busy cycle,
    // so MDU_WAIT begins at MDU_LAT-2.
    localparam logic [CNT_W-1:0] MDU_INIT  = CNT_W'(MDU_LAT - 2);
    localparam logic [CNT_W-1:0] KILL_INIT = CNT_W'(KILL_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic load_use_s;
    logic pc_hold_s, if_id_stall_s, if_id_flush_s;
    logic id_ex_stall_s, id_ex_flush_s, ex_stall_s, mdu_done_s;
    logic redirect_acc_s;

    // A load in EX feeds a source that ID reads. x0 never creates a hazard.
    assign load_use_s = ex_mem_read && (ex_rd != '0) &&
                        ((id_rs1_used && (id_rs1 == ex_rd)) ||
                         (id_rs2_used && (id_rs2 == ex_rd)));

    // Next-state and control decode. In RUN the priority is:
    // redirect, then mdu start, then load-use.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        pc_hold_s      = 1'b0;
        if_id_stall_s  = 1'b0;
        if_id_flush_s  = 1'b0;
        id_ex_stall_s  = 1'b0;
        id_ex_flush_s  = 1'b0;
        ex_stall_s     = 1'b0;
        mdu_done_s     = 1'b0;
        redirect_acc_s = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (ex_redirect) begin
                    if_id_flush_s  = 1'b1;
                    id_ex_flush_s  = 1'b1;
                    redirect_acc_s = 1'b1;
                    if (KILL_CYCLES > 0) begin
                        state_d = ST_KILL;
                        cnt_d   = KILL_INIT;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else if (ex_mdu_start) begin
                    if (MDU_LAT > 1) begin
                        pc_hold_s     = 1'b1;
                        if_id_stall_s = 1'b1;
                        id_ex_stall_s = 1'b1;
                        ex_stall_s    = 1'b1;
                        state_d       = ST_MDU_WAIT;
                        cnt_d         = MDU_INIT;
                    end else begin
                        mdu_done_s = 1'b1;
                    end
                end else if (load_use_s) begin
                    pc_hold_s     = 1'b1;
                    if_id_stall_s = 1'b1;
                    id_ex_flush_s = 1'b1;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_MDU_WAIT: begin
                pc_hold_s     = 1'b1;
                if_id_stall_s = 1'b1;
                id_ex_stall_s = 1'b1;
                ex_stall_s    = 1'b1;
                if (cnt_q == '0) begin
                    mdu_done_s = 1'b1;
                    state_d    = ST_RUN;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_KILL: begin
                if_id_flush_s = 1'b1;
                if (ex_redirect) begin
                    id_ex_flush_s  = 1'b1;
                    redirect_acc_s = 1'b1;
                    cnt_d          = KILL_INIT;
                end else if (cnt_q == '0) begin
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
        endcase
    end

    // Output gating: reset silences every control. A flush beats a stall
    // on if_id.
    always_comb begin
        if (reset) begin
            pc_hold     = 1'b0;
            if_id_stall = 1'b0;
            if_id_flush = 1'b0;
            id_ex_stall = 1'b0;
            id_ex_flush = 1'b0;
            ex_stall    = 1'b0;
            mdu_done    = 1'b0;
        end else begin
            pc_hold     = pc_hold_s;
            if_id_stall = if_id_stall_s && !if_id_flush_s;
            if_id_flush = if_id_flush_s;
            id_ex_stall = id_ex_stall_s && !id_ex_flush_s;
            id_ex_flush = id_ex_flush_s;
            ex_stall    = ex_stall_s;
            mdu_done    = mdu_done_s;
        end
    end

    // FSM state and down-counter. Reset aborts any wait or kill window.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    // Event counters: cycles with the PC held, and accepted redirects.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            perf_stall_cnt <= 32'd0;
            perf_flush_cnt <= 32'd0;
        end else begin
            perf_stall_cnt <= perf_stall_cnt + {31'd0, pc_hold};
            perf_flush_cnt <= perf_flush_cnt + {31'd0, redirect_acc_s};
        end
    end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl. It uses MDU_LAT=4 and KILL_CYCLES=2.
module tb_pipe_ctrl;

    // Output order: {pc_hold, if_id_stall, if_id_flush, id_ex_stall,
    //                id_ex_flush, ex_stall, mdu_done}
    localparam logic [6:0] O_NONE = 7'b0000000;
    localparam logic [6:0] O_LU   = 7'b1100100;
    localparam logic [6:0] O_MDUS = 7'b1101010;
    localparam logic [6:0] O_MDUD = 7'b1101011;
    localparam logic [6:0] O_RED  = 7'b0010100;
    localparam logic [6:0] O_KILL = 7'b0010000;

    typedef struct {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] rd;
        logic       mr;
        logic       ms;
        logic       redir;
        logic [6:0] exp;
    } vec_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] id_rs1 = 5'd0, id_rs2 = 5'd0, ex_rd = 5'd0;
    logic       id_rs1_used = 1'b0, id_rs2_used = 1'b0;
    logic       ex_mem_read = 1'b0, ex_mdu_start = 1'b0, ex_redirect = 1'b0;
    logic       pc_hold, if_id_stall, if_id_flush, id_ex_stall;
    logic       id_ex_flush, ex_stall, mdu_done;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] perf_stall_cnt, perf_flush_cnt;
`endif

    int checks   = 0;
    int failures = 0;
    logic [6:0] exp_q[$];
    vec_t       tbl[9];

    pipe_ctrl #(
        .REG_ADDR_W(5), .MDU_LAT(4), .KILL_CYCLES(2), .CNT_W(6)
    ) dut (
        .clock(clock), .reset(reset),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
        .ex_mdu_start(ex_mdu_start), .ex_redirect(ex_redirect),
        .pc_hold(pc_hold), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
        .id_ex_stall(id_ex_stall), .id_ex_flush(id_ex_flush),
        .ex_stall(ex_stall), .mdu_done(mdu_done)
`ifdef PIPE_CTRL_PERF_EN
        ,
        .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
    );

    always #5 clock = ~clock;

    function automatic vec_t mk(input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic u1, input logic u2,
                                input logic [4:0] rd, input logic mr,
                                input logic ms, input logic redir,
                                input logic [6:0] exp);
        vec_t v;
        v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2; v.rd = rd;
        v.mr = mr; v.ms = ms; v.redir = redir; v.exp = exp;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        id_rs1 = v.rs1; id_rs2 = v.rs2; id_rs1_used = v.u1; id_rs2_used = v.u2;
        ex_rd = v.rd; ex_mem_read = v.mr; ex_mdu_start = v.ms; ex_redirect = v.redir;
        exp_q.push_back(v.exp);
    endtask

    task automatic compare(input string tag);
        logic [6:0] got, e;
        got = {pc_hold, if_id_stall, if_id_flush, id_ex_stall,
               id_ex_flush, ex_stall, mdu_done};
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL %s: scoreboard empty, got %b", tag, got);
        end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
                failures++;
                $display("FAIL %s @%0t: got %b want %b", tag, $time, got, e);
            end
        end
    endtask

    // Drive one cycle, check at the falling edge, then move past the next rising edge.
    task automatic step(input vec_t v, input string tag);
        drive(v);
        @(negedge clock);
        compare(tag);
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input logic [6:0] exp, input string tag);
        step(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, exp), tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Single-cycle vectors, each applied in RUN state.
        tbl[0] = mk(5'd0,  5'd0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, O_NONE);
        tbl[1] = mk(5'd1,  5'd5, 1'b0, 1'b1, 5'd5,  1'b1, 1'b0, 1'b0, O_LU);
        tbl[2] = mk(5'd1,  5'd0, 1'b0, 1'b1, 5'd0,  1'b1, 1'b0, 1'b0, O_NONE);
        tbl[3] = mk(5'd7,  5'd2, 1'b1, 1'b0, 5'd7,  1'b1, 1'b0, 1'b0, O_LU);
        tbl[4] = mk(5'd7,  5'd2, 1'b0, 1'b0, 5'd7,  1'b1, 1'b0, 1'b0, O_NONE);
        tbl[5] = mk(5'd7,  5'd2, 1'b1, 1'b0, 5'd7,  1'b0, 1'b0, 1'b0, O_NONE);
        tbl[6] = mk(5'd3,  5'd5, 1'b1, 1'b0, 5'd5,  1'b1, 1'b0, 1'b0, O_NONE);
        tbl[7] = mk(5'd31, 5'd4, 1'b1, 1'b1, 5'd31, 1'b1, 1'b0, 1'b0, O_LU);
        tbl[8] = mk(5'd9,  5'd9, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0, O_NONE);

        // Reset state: outputs must be 0 even with active inputs.
        ex_redirect = 1'b1;
        ex_mdu_start = 1'b1;
        exp_q.push_back(O_NONE);
        @(negedge clock);
        compare("reset_outputs");
        ex_redirect = 1'b0;
        ex_mdu_start = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b0;

        for (int i = 0; i < 9; i++) begin
            step(tbl[i], $sformatf("vec%0d", i));
        end

        // Load-use clears after exactly one cycle once the load moves on.
        step(tbl[1], "lu_once");
        idle(O_NONE, "lu_cleared");

        // MDU latency 4. A redirect and a load-use during the wait are ignored.
        step(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, O_MDUS), "mdu_c0");
        step(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, O_MDUS), "mdu_c1_redir_ign");
        step(mk(5'd1, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, O_MDUS), "mdu_c2_lu_ign");
        idle(O_MDUD, "mdu_c3_done");
        idle(O_NONE, "mdu_c4_run");

        // Redirect with KILL_CYCLES=2. A load-use during KILL is ignored.
        step(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, O_RED), "red_c0");
        step(mk(5'd1, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, O_KILL), "red_c1_lu_ign");
        idle(O_KILL, "red_c2");
        idle(O_NONE, "red_c3_run");

        // Redirect beats mdu_start. A redirect during KILL restarts the window.
        step(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, O_RED), "sim_c0");
        idle(O_KILL, "sim_c1");
        step(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, O_RED), "sim_c2_restart");
        idle(O_KILL, "sim_c3");
        idle(O_KILL, "sim_c4");
        idle(O_NONE, "sim_c5_run");

        // Reset asserted in the third MDU cycle aborts the wait with no done pulse.
        step(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, O_MDUS), "rst_mdu_c0");
        idle(O_MDUS, "rst_mdu_c1");
        reset = 1'b1;
        exp_q.push_back(O_NONE);
        #1;
        compare("rst_async_zero");
        @(posedge clock);
        #1;
        reset = 1'b0;
        idle(O_NONE, "rst_after_a");
        idle(O_NONE, "rst_after_b");
        step(tbl[1], "rst_after_lu");

`ifdef PIPE_CTRL_PERF_EN
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        step(tbl[1], "perf_lu");
        step(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, O_MDUS), "perf_m0");
        idle(O_MDUS, "perf_m1");
        idle(O_MDUS, "perf_m2");
        idle(O_MDUD, "perf_m3");
        step(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, O_RED), "perf_r0");
        step(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, O_RED), "perf_r1");
        idle(O_KILL, "perf_r2");
        idle(O_KILL, "perf_r3");
        checks++;
        if (perf_stall_cnt !== 32'd5) begin
            failures++;
            $display("FAIL perf_stall: got %0d want 5", perf_stall_cnt);
        end
        checks++;
        if (perf_flush_cnt !== 32'd2) begin
            failures++;
            $display("FAIL perf_flush: got %0d want 2", perf_flush_cnt);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central stall/flush scheduler for the in-order RISC-V core pipeline.
- Drives the hold and flush controls of the PC register and the if_id, id_ex and ex stage registers.
- Resolves three hazard sources: load-use, multi-cycle mul/div occupancy, and control-flow redirect (including kill of stale fetches still in flight).
- Sits beside the datapath. It decides only and holds no datapath data.

Parameters:
- REG_ADDR_W, 5, register index width.
- MDU_LAT, 32, mul/div busy cycles; legal range 1..2^CNT_W.
- KILL_CYCLES, 1, extra cycles if_id is flushed after a redirect; legal range 0..2^CNT_W-1.
- CNT_W, 6, width of the internal down-counter.

Ports:
- clock in 1: core clock.
- reset in 1: asynchronous, active-high reset.
- id_rs1 in REG_ADDR_W: source register 1 of the instruction in ID.
- id_rs2 in REG_ADDR_W: source register 2 of the instruction in ID.
- id_rs1_used in 1: ID instruction reads rs1.
- id_rs2_used in 1: ID instruction reads rs2.
- ex_rd in REG_ADDR_W: destination register of the instruction in EX.
- ex_mem_read in 1: EX instruction is a load.
- ex_mdu_start in 1: EX instruction starts mul/div (single-cycle pulse).
- ex_redirect in 1: branch taken or jump resolved in EX; the PC loads the target this cycle.
- pc_hold out 1: PC keeps its value.
- if_id_stall out 1: if_id register holds.
- if_id_flush out 1: if_id loads zero PC / NONE instruction.
- id_ex_stall out 1: id_ex register holds.
- id_ex_flush out 1: id_ex loads a bubble.
- ex_stall out 1: EX stage and ex/mem register hold.
- mdu_done out 1: one-cycle pulse in the final busy cycle.

Behaviour:
- Reset:
  - Asynchronous. state=RUN, cnt=0.
  - All outputs are forced to 0 while reset=1.
  - Reset mid-MDU_WAIT or mid-KILL aborts immediately, with no done pulse.
- States:
  - RUN: normal flow.
  - MDU_WAIT: mul/div busy.
  - KILL: discarding stale fetches.
- Outputs are combinational from state and inputs. State and cnt update on posedge clock.
- RUN, priority redirect > mdu_start > load-use:
  - ex_redirect=1:
    - if_id_flush=1, id_ex_flush=1, pc_hold=0.
    - If KILL_CYCLES>0: next=KILL, cnt=KILL_CYCLES-1. Otherwise stay in RUN.
    - ex_mdu_start is ignored this cycle.
  - ex_mdu_start=1, MDU_LAT>1:
    - pc_hold, if_id_stall, id_ex_stall and ex_stall are all 1 this cycle.
    - next=MDU_WAIT, cnt=MDU_LAT-2.
  - ex_mdu_start=1, MDU_LAT=1: mdu_done=1 this cycle, no stall, stay in RUN.
  - Load-use:
    - Condition: ex_mem_read=1 and ex_rd!=0 and ((id_rs1_used and id_rs1==ex_rd) or (id_rs2_used and id_rs2==ex_rd)).
    - Response: pc_hold=1, if_id_stall=1, id_ex_flush=1 (one bubble).
    - Combinational only, no state change. It clears naturally the next cycle.
    - Register x0 never causes a hazard.
- MDU_WAIT:
  - pc_hold, if_id_stall, id_ex_stall and ex_stall are all 1.
  - cnt decrements each cycle.
  - When cnt==0: mdu_done=1 and the stalls are still 1 in that cycle; next=RUN.
  - Total stall cycles including the start cycle = MDU_LAT.
  - ex_redirect, ex_mdu_start and load-use are ignored in this state.
- KILL:
  - if_id_flush=1. All other outputs 0, so the PC advances.
  - cnt==0 leads to next=RUN.
  - ex_redirect=1 in KILL: id_ex_flush=1 as well, and the kill window restarts with cnt=KILL_CYCLES-1.
  - Load-use and mdu_start are not evaluated in KILL.
- A flush and a stall on the same register in the same cycle: flush wins (if_id_flush overrides if_id_stall).

Optional Feature:
- Macro: PIPE_CTRL_PERF_EN.
- Defined:
  - Adds outputs perf_stall_cnt[31:0] and perf_flush_cnt[31:0].
  - perf_stall_cnt increments every cycle pc_hold=1.
  - perf_flush_cnt increments on every accepted ex_redirect.
  - Both counters wrap at 2^32 and reset to 0.
- Undefined: the ports and counters are absent, and the rest of the behaviour is identical.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=5, id_rs2=5, id_rs2_used=1 → exactly 1 cycle of pc_hold=1, if_id_stall=1, id_ex_flush=1. Repeat with ex_rd=0 → no stall.
- MDU (MDU_LAT=4): ex_mdu_start pulse at cycle 0 → ex_stall=1 during cycles 0-3, mdu_done=1 only in cycle 3, all stalls 0 in cycle 4.
- Redirect (KILL_CYCLES=2): ex_redirect at cycle 0 → if_id_flush=1 in cycles 0-2, id_ex_flush=1 only in cycle 0, pc_hold=0 throughout.
- Simultaneous events: ex_redirect=1 with ex_mdu_start=1 → state KILL, no ex_stall. Redirect during KILL → window restarts, flush lasts 2 more cycles.
- Reset mid-MDU_WAIT at cycle 2 → outputs 0 immediately (asynchronous), no mdu_done, state RUN after release.
- With PIPE_CTRL_PERF_EN: the above sequence → perf_stall_cnt=5 (1 load-use + 4 MDU), perf_flush_cnt=2.
